// File: rtl/seq2b8_game.sv
// rtl/seq2b8_game.sv - Simon-style memory game core: 4 lamps, 4 buttons, 8 levels
module seq2b8_game #(
    parameter int SHOW_CYC = 2,
    parameter int GAP_CYC  = 1,
    parameter int FAIL_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       on,
    input  logic       setzero,
    input  logic       start,
    input  logic [3:0] b,
    output logic [3:0] l,
    output logic       win
);

    localparam int MAX_AB  = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_AB > FAIL_CYC) ? MAX_AB : FAIL_CYC;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW_ON,
        S_SHOW_GAP,
        S_WAIT_IN,
        S_FAIL,
        S_WIN
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    level_q, level_d;
    logic [2:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   seq_q, seq_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [3:0]    b_prev_q;
    logic [3:0]    l_q, l_d;
    logic          win_q, win_d;

    logic [1:0]    sym_cur;
    logic [1:0]    sym_nxt;
    logic          press;
    logic          press_ok;

    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign sym_cur  = seq_q[{idx_q, 1'b0} +: 2];
    assign press    = (b != 4'b0000) && (b_prev_q == 4'b0000);
    assign press_ok = (b == (4'b0001 << sym_cur));

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        seq_d   = seq_q;
        l_d     = 4'b0000;
        win_d   = 1'b0;
        sym_nxt = 2'd0;

        if (!on || setzero) begin
            state_d = S_IDLE;
            level_d = 3'd0;
            idx_d   = 3'd0;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        seq_d   = lfsr_q;
                        level_d = 3'd0;
                        idx_d   = 3'd0;
                        timer_d = '0;
                        state_d = S_SHOW_ON;
                    end
                end
                S_SHOW_ON: begin
                    if (timer_q == TW'(SHOW_CYC - 1)) begin
                        timer_d = '0;
                        state_d = S_SHOW_GAP;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_SHOW_GAP: begin
                    if (timer_q == TW'(GAP_CYC - 1)) begin
                        timer_d = '0;
                        if (idx_q == level_q) begin
                            idx_d   = 3'd0;
                            state_d = S_WAIT_IN;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = S_SHOW_ON;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_WAIT_IN: begin
                    if (press) begin
                        timer_d = '0;
                        if (!press_ok) begin
                            state_d = S_FAIL;
                        end else if (idx_q < level_q) begin
                            idx_d = idx_q + 3'd1;
                        end else if (level_q == 3'd7) begin
                            state_d = S_WIN;
                        end else begin
                            level_d = level_q + 3'd1;
                            idx_d   = 3'd0;
                            state_d = S_SHOW_ON;
                        end
                    end
                end
                S_FAIL: begin
                    if (timer_q == TW'(FAIL_CYC - 1)) begin
                        timer_d = '0;
                        level_d = 3'd0;
                        idx_d   = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_WIN: begin
                    state_d = S_WIN;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Lamps are decoded from the next state so they track the deciding edge.
        sym_nxt = seq_d[{idx_d, 1'b0} +: 2];
        case (state_d)
            S_SHOW_ON: l_d   = 4'b0001 << sym_nxt;
            S_FAIL:    l_d   = 4'b1111;
            S_WIN:     win_d = 1'b1;
            default:   l_d   = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            level_q  <= 3'd0;
            idx_q    <= 3'd0;
            timer_q  <= '0;
            seq_q    <= 16'h0000;
            lfsr_q   <= 16'h0001;
            b_prev_q <= 4'b0000;
            l_q      <= 4'b0000;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            seq_q    <= seq_d;
            lfsr_q   <= lfsr_d;
            b_prev_q <= b;
            l_q      <= l_d;
            win_q    <= win_d;
        end
    end

    assign l   = l_q;
    assign win = win_q;

endmodule

// File: tb/tb_seq2b8_game.sv
// tb/tb_seq2b8_game.sv - directed self-checking bench for seq2b8_game
module tb_seq2b8_game;

    logic       clk;
    logic       reset;
    logic       on;
    logic       setzero;
    logic       start;
    logic [3:0] b;
    logic [3:0] l;
    logic       win;

    int          pass_cnt;
    int          total_cnt;
    logic [15:0] lfsr_m;
    logic [15:0] s;

    seq2b8_game dut (
        .clk     (clk),
        .reset   (reset),
        .on      (on),
        .setzero (setzero),
        .start   (start),
        .b       (b),
        .l       (l),
        .win     (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic chk16(input logic [15:0] obs, input logic [15:0] exp, input string tag);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One clock: inputs already set; sample outputs on the following falling edge.
    task automatic tick(input logic [3:0] exp_l, input logic exp_win, input string tag);
        logic rst_at_edge;
        @(posedge clk);
        rst_at_edge = reset;
        @(negedge clk);
        lfsr_m = rst_at_edge ? lfsr_step(lfsr_m) : 16'h0001;
        total_cnt++;
        assert (l === exp_l) pass_cnt++;
        else $error("FAIL %s l: got %b expected %b", tag, l, exp_l);
        total_cnt++;
        assert (win === exp_win) pass_cnt++;
        else $error("FAIL %s win: got %b expected %b", tag, win, exp_win);
    endtask

    task automatic replay_check(input int n, input logic [15:0] sq, input bit clr_b);
        logic [3:0] sl;
        for (int i = 0; i < n; i++) begin
            sl = 4'b0001 << sq[2*i +: 2];
            tick(sl, 1'b0, "show_a");
            if (i == 0) begin
                start = 1'b0;
                if (clr_b) b = 4'b0000;
            end
            tick(sl, 1'b0, "show_b");
            tick(4'b0000, 1'b0, "gap");
        end
        tick(4'b0000, 1'b0, "wait_in");
    endtask

    task automatic press_mid(input logic [3:0] bv);
        b = bv;
        tick(4'b0000, 1'b0, "press_mid");
        b = 4'b0000;
        tick(4'b0000, 1'b0, "release");
    endtask

    task automatic fail_check(input string tag);
        for (int i = 0; i < 4; i++) begin
            tick(4'b1111, 1'b0, tag);
            b = 4'b0000;
        end
        tick(4'b0000, 1'b0, "fail_to_idle");
    endtask

    // From WAIT_IN of level 1 with seq 0001: sym0 = 1, every other symbol = 0.
    task automatic play_to_win();
        for (int n = 1; n <= 8; n++) begin
            for (int i = 0; i < n - 1; i++)
                press_mid((i == 0) ? 4'b0010 : 4'b0001);
            b = (n == 1) ? 4'b0010 : 4'b0001;
            if (n < 8) begin
                replay_check(n + 1, 16'h0001, 1'b1);
            end else begin
                tick(4'b0000, 1'b1, "win_enter");
                b = 4'b0000;
                tick(4'b0000, 1'b1, "win_hold");
            end
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        lfsr_m    = 16'h0001;
        reset     = 1'b0;
        on        = 1'b1;
        setzero   = 1'b0;
        start     = 1'b0;
        b         = 4'b0000;

        tick(4'b0000, 1'b0, "rst1");
        tick(4'b0000, 1'b0, "rst2");
        chk16(dut.lfsr_q, 16'h0001, "rst_lfsr");

        reset = 1'b1;
        start = 1'b1;
        replay_check(1, 16'h0001, 1'b1);
        chk16(dut.seq_q, 16'h0001, "seq_capture");

        b = 4'b0010;
        replay_check(2, 16'h0001, 1'b1);
        press_mid(4'b0010);
        b = 4'b0001;
        replay_check(3, 16'h0001, 1'b1);

        b = 4'b0100;
        fail_check("wrong_press");

        reset = 1'b0;
        tick(4'b0000, 1'b0, "rst3");
        reset = 1'b1;
        start = 1'b1;
        replay_check(1, 16'h0001, 1'b1);
        play_to_win();
        start = 1'b1;
        tick(4'b0000, 1'b1, "win_start_ignored");
        start   = 1'b0;
        setzero = 1'b1;
        tick(4'b0000, 1'b0, "setzero");
        setzero = 1'b0;
        tick(4'b0000, 1'b0, "idle_after_sz");

        s     = lfsr_m;
        start = 1'b1;
        replay_check(1, s, 1'b1);
        chk16(dut.seq_q, s, "seq_fresh");
        b = 4'b0011;
        fail_check("multibit");

        s     = lfsr_m;
        start = 1'b1;
        b     = 4'b0001 << s[1:0];
        replay_check(1, s, 1'b0);
        tick(4'b0000, 1'b0, "held_no_event");
        b = 4'b0000;
        tick(4'b0000, 1'b0, "held_release");
        b = 4'b0001 << s[1:0];
        replay_check(2, s, 1'b1);

        press_mid(4'b0001 << s[1:0]);
        b = 4'b0001 << s[3:2];
        tick(4'b0001 << s[1:0], 1'b0, "l3_show_a");
        b = 4'b0000;
        tick(4'b0001 << s[1:0], 1'b0, "l3_show_b");
        on = 1'b0;
        tick(4'b0000, 1'b0, "on_off");
        chk16(dut.lfsr_q, lfsr_m, "lfsr_runs_off");
        on = 1'b1;
        tick(4'b0000, 1'b0, "idle_after_on");

        reset = 1'b0;
        tick(4'b0000, 1'b0, "rst4");
        reset = 1'b1;
        start = 1'b1;
        replay_check(1, 16'h0001, 1'b1);
        play_to_win();
        reset = 1'b0;
        tick(4'b0000, 1'b0, "reset_in_win");
        reset = 1'b1;
        tick(4'b0000, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
